control_queue_mc: RTL

// - In-order queue for control-flow ops (branch/jal/jalr/auipc) between dispatch and commit.
// - Entries resolve out of order through NUM_UPD broadcast channels matched on rob_idx.
// - The head pops only once it is resolved.
// - Over the single-port queue it adds: N update channels, same-cycle enqueue/update bypass,

---
 rtl/control_queue_mc_pkg.sv | 54 +++++
 rtl/control_queue_mc_upd_match.sv | 28 ++
 rtl/control_queue_mc.sv | 132 +++++++++++++
 3 files changed

// File: rtl/control_queue_mc_pkg.sv
// Shared types and sizes for the control-flow queue.
// Contents: sizing localparams, op-type enum, queue entry and update-channel payloads,
// and a helper that folds an update payload into an entry.
package control_queue_mc_pkg;

    localparam int unsigned ROB_IDX_W    = 4;
    localparam int unsigned ARCH_REG_W   = 5;
    localparam int unsigned PHYS_REG_W   = 6;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned CTRL_Q_DEPTH = 8;

    // auipc_entry is the all-zero encoding so a cleared entry reads as auipc
    typedef enum logic [1:0] {
        auipc_entry  = 2'd0,
        branch_entry = 2'd1,
        jal_entry    = 2'd2,
        jalr_entry   = 2'd3
    } ctrl_op_t;

    typedef struct packed {
        logic                  valid;
        logic                  resolved;
        ctrl_op_t              mem_op_type;
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [ARCH_REG_W-1:0] rd;
        logic [PHYS_REG_W-1:0] pd;
        logic [XLEN-1:0]       pc_in;
        logic [XLEN-1:0]       pc_new;
        logic                  br_en;
        logic [XLEN-1:0]       rs1_v;
        logic [XLEN-1:0]       rs2_v;
    } ctrl_q_entry_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      pc_new;
        logic                 br_en;
        logic [XLEN-1:0]      rs1_v;
        logic [XLEN-1:0]      rs2_v;
    } ctrl_q_upd_t;

    // Mark an entry resolved and copy in the broadcast results
    function automatic ctrl_q_entry_t apply_upd(input ctrl_q_entry_t e, input ctrl_q_upd_t u);
        ctrl_q_entry_t r;
        r          = e;
        r.resolved = 1'b1;
        r.pc_new   = u.pc_new;
        r.br_en    = u.br_en;
        r.rs1_v    = u.rs1_v;
        r.rs2_v    = u.rs2_v;
        return r;
    endfunction

endpackage

// File: rtl/control_queue_mc_upd_match.sv
// ctrl_q_upd_match: matches one rob_idx against all update channels.
// Ports: rob_idx_i (tag to match), upd_valid_i/upd_i (broadcast channels),
//        hit_c (any channel matched), sel_c (payload of lowest matching channel).
module ctrl_q_upd_match
    import control_queue_mc_pkg::*;
#(
    parameter int unsigned NUM_UPD = 2
) (
    input  logic [ROB_IDX_W-1:0]            rob_idx_i,
    input  logic [NUM_UPD-1:0]              upd_valid_i,
    input  ctrl_q_upd_t [NUM_UPD-1:0]       upd_i,
    output logic                            hit_c,
    output ctrl_q_upd_t                     sel_c
);

    // Walk from the highest channel down so the lowest hit overwrites last
    always_comb begin
        hit_c = 1'b0;
        sel_c = '0;
        for (int c = int'(NUM_UPD) - 1; c >= 0; c--) begin
            if (upd_valid_i[c] && (upd_i[c].rob_idx == rob_idx_i)) begin
                hit_c = 1'b1;
                sel_c = upd_i[c];
            end
        end
    end

endmodule

// File: rtl/control_queue_mc.sv
// control_queue_mc: in-order queue of control-flow ops between dispatch and commit.
// Entries resolve out of order via NUM_UPD broadcast channels; the head pops only once resolved.
// Ports: clk, rst (async active-low), flush (sync clear),
//        enq_valid/enq_entry/enq_ready (dispatch side),
//        upd_valid/upd (resolution broadcasts),
//        deq_valid/deq_ready/deq_entry (commit side), count/empty/full (occupancy).
module control_queue_mc
    import control_queue_mc_pkg::*;
#(
    parameter  int unsigned DEPTH   = CTRL_Q_DEPTH,
    parameter  int unsigned NUM_UPD = 2,
    localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  ctrl_q_entry_t              enq_entry,
    output logic                       enq_ready,
    input  logic [NUM_UPD-1:0]         upd_valid,
    input  ctrl_q_upd_t [NUM_UPD-1:0]  upd,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output ctrl_q_entry_t              deq_entry,
    output logic [PTR_W:0]             count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PW = PTR_W + 1;

    // Pointers carry an extra wrap bit to tell full from empty
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;
    ctrl_q_entry_t  entries_q [DEPTH];
    ctrl_q_entry_t  entries_d [DEPTH];

    logic [DEPTH-1:0] ent_hit_c;
    ctrl_q_upd_t      ent_sel_c [DEPTH];
    logic             byp_hit_c;
    ctrl_q_upd_t      byp_sel_c;

    logic enq_fire_c;
    logic deq_fire_c;

    // One matcher per stored entry
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        ctrl_q_upd_match #(.NUM_UPD(NUM_UPD)) u_match (
            .rob_idx_i   (entries_q[i].rob_idx),
            .upd_valid_i (upd_valid),
            .upd_i       (upd),
            .hit_c       (ent_hit_c[i]),
            .sel_c       (ent_sel_c[i])
        );
    end

    // Matcher for the entry arriving this cycle
    ctrl_q_upd_match #(.NUM_UPD(NUM_UPD)) u_byp_match (
        .rob_idx_i   (enq_entry.rob_idx),
        .upd_valid_i (upd_valid),
        .upd_i       (upd),
        .hit_c       (byp_hit_c),
        .sel_c       (byp_sel_c)
    );

    // Status decoded straight from the pointer/entry registers
    assign empty     = (head_q == tail_q);
    assign full      = (head_q[PTR_W] != tail_q[PTR_W]) &&
                       (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
    assign count     = tail_q - head_q;
    assign enq_ready = !full;
    assign deq_entry = entries_q[head_q[PTR_W-1:0]];
    assign deq_valid = !empty && deq_entry.resolved;

    assign enq_fire_c = enq_valid && enq_ready;
    assign deq_fire_c = deq_valid && deq_ready;

    // Next-state: updates, then pop clear, then push write; the three never touch the same slot
    always_comb begin
        ctrl_q_entry_t new_ent;
        head_d    = head_q;
        tail_d    = tail_q;
        entries_d = entries_q;
        new_ent   = '0;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_d[i] = '0;
            end
        end else begin
            // Only live, unresolved entries accept results; first write sticks
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (entries_q[i].valid && !entries_q[i].resolved && ent_hit_c[i]) begin
                    entries_d[i] = apply_upd(entries_q[i], ent_sel_c[i]);
                end
            end

            if (deq_fire_c) begin
                entries_d[head_q[PTR_W-1:0]] = '0;
                head_d = head_q + PW'(1);
            end

            if (enq_fire_c) begin
                new_ent       = enq_entry;
                new_ent.valid = 1'b1;
                if (!enq_entry.resolved && byp_hit_c) begin
                    new_ent = apply_upd(new_ent, byp_sel_c);
                end
                entries_d[tail_q[PTR_W-1:0]] = new_ent;
                tail_d = tail_q + PW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

endmodule
